// File: rtl/delay_meter.sv
// Measures the clk-cycle interval from a rising edge on start to the next rising edge on stop.
// The result is held behind a valid/ready handshake, and a timeout flag marks intervals of 2^WIDTH or more.
module delay_meter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  output logic             timeout,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StMeasure, StDone} state_e;

  localparam logic [WIDTH-1:0] Max = {WIDTH{1'b1}};

  state_e           r_state, w_state_d;
  logic [WIDTH-1:0] r_count, w_count_d;
  logic [WIDTH-1:0] r_result, w_result_d;
  logic             r_valid, w_valid_d;
  logic             r_timeout, w_timeout_d;
  logic             r_busy, w_busy_d;
  logic             r_start_q, r_stop_q;
  logic             w_start_rise, w_stop_rise;

  assign w_start_rise = start & ~r_start_q;
  assign w_stop_rise  = stop & ~r_stop_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= StIdle;
      r_count   <= '0;
      r_result  <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      r_start_q <= 1'b0;
      r_stop_q  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_count   <= w_count_d;
      r_result  <= w_result_d;
      r_valid   <= w_valid_d;
      r_timeout <= w_timeout_d;
      r_busy    <= w_busy_d;
      r_start_q <= start;
      r_stop_q  <= stop;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_count_d   = r_count;
    w_result_d  = r_result;
    w_valid_d   = r_valid;
    w_timeout_d = r_timeout;
    w_busy_d    = r_busy;
    unique case (r_state)
      StIdle: begin
        if (w_start_rise) begin
          w_state_d = StMeasure;
          w_count_d = '0;
          w_busy_d  = 1'b1;
        end
      end
      StMeasure: begin
        // Saturation is checked before the increment so count never wraps.
        if (r_count == Max) begin
          w_state_d   = StDone;
          w_result_d  = Max;
          w_timeout_d = 1'b1;
          w_valid_d   = 1'b1;
          w_busy_d    = 1'b0;
        end else if (w_stop_rise) begin
          w_state_d   = StDone;
          w_result_d  = r_count + 1'b1;
          w_timeout_d = 1'b0;
          w_valid_d   = 1'b1;
          w_busy_d    = 1'b0;
        end else if (w_start_rise) begin
          w_count_d = '0;
        end else begin
          w_count_d = r_count + 1'b1;
        end
      end
      StDone: begin
        if (result_ready) begin
          w_state_d = StIdle;
          w_valid_d = 1'b0;
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  assign result       = r_result;
  assign result_valid = r_valid;
  assign timeout      = r_timeout;
  assign busy         = r_busy;

endmodule

// File: tb/tb_delay_meter.sv
// Bench for delay_meter: directed scenarios plus random stimulus, checked every cycle against a
// model that timestamps the start edge and derives results from edge-to-edge distance.
module tb_delay_meter;

  localparam int unsigned WIDTH = 8;
  localparam int Max = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             timeout;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  delay_meter #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .result_ready (result_ready),
    .result       (result),
    .result_valid (result_valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: phase 0=idle, 1=measuring, 2=holding a result.
  int   m_phase, m_cyc, m_t0, m_res;
  logic m_val, m_to, m_busy, m_sp, m_tp;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0;
      m_res   = 0;
      m_val   = 1'b0;
      m_to    = 1'b0;
      m_busy  = 1'b0;
      m_sp    = 1'b0;
      m_tp    = 1'b0;
    end else begin
      logic s_r, p_r;
      int   elapsed;
      m_cyc++;
      s_r = start && !m_sp;
      p_r = stop && !m_tp;
      elapsed = m_cyc - m_t0;
      if (m_phase == 0) begin
        if (s_r) begin
          m_phase = 1;
          m_t0    = m_cyc;
          m_busy  = 1'b1;
        end
      end else if (m_phase == 1) begin
        if (elapsed > Max) begin
          m_phase = 2; m_res = Max; m_to = 1'b1; m_val = 1'b1; m_busy = 1'b0;
        end else if (p_r) begin
          m_phase = 2; m_res = elapsed; m_to = 1'b0; m_val = 1'b1; m_busy = 1'b0;
        end else if (s_r) begin
          m_t0 = m_cyc;
        end
      end else if (result_ready) begin
        m_phase = 0;
        m_val   = 1'b0;
      end
      m_sp = start;
      m_tp = stop;
    end
  end

  always @(negedge clk) begin
    check("result", int'(result), m_res);
    check("result_valid", int'(result_valid), int'(m_val));
    check("timeout", int'(timeout), int'(m_to));
    check("busy", int'(busy), int'(m_busy));
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_stop(input int gap);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(gap - 1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(3);
  endtask

  initial begin
    m_cyc = 0;
    m_t0  = 0;
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    result_ready = 1'b0;
    step(5);
    reset = 1'b0;
    step(2);

    // Basic, minimum, and simultaneous start/stop in idle.
    result_ready = 1'b1;
    start_stop(10);
    start_stop(1);
    start = 1'b1; stop = 1'b1;
    step(1);
    start = 1'b0; stop = 1'b0;
    step(4);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(3);

    // Timeout, with a late stop ignored while the result is pending.
    result_ready = 1'b0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(262);
    check("timeout_flag", int'(timeout), 1);
    check("timeout_result", int'(result), Max);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(2);
    result_ready = 1'b1;
    step(2);

    // Boundary: interval of exactly Max completes without timeout.
    start_stop(Max);
    check("max_interval", int'(result), Max);
    check("max_no_timeout", int'(timeout), 0);

    // Restart, then stop beating a simultaneous start.
    start = 1'b1; step(1); start = 1'b0; step(3);
    start = 1'b1; step(1); start = 1'b0; step(5);
    stop = 1'b1; step(1); stop = 1'b0; step(3);
    start = 1'b1; step(1); start = 1'b0; step(6);
    start = 1'b1; stop = 1'b1; step(1); start = 1'b0; stop = 1'b0; step(3);

    // Handshake hold with new starts ignored.
    result_ready = 1'b0;
    start_stop(4);
    for (int i = 0; i < 20; i++) begin
      start = (i % 4 == 1);
      step(1);
    end
    start = 1'b0;
    check("hold_valid", int'(result_valid), 1);
    check("hold_result", int'(result), 4);
    result_ready = 1'b1;
    step(1);
    start_stop(3);
    check("after_hold", int'(result), 3);

    // Asynchronous reset mid-measurement.
    start = 1'b1; step(1); start = 1'b0; step(4);
    #1 reset = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(result_valid), 0);
    check("rst_result", int'(result), 0);
    check("rst_timeout", int'(timeout), 0);
    step(2);
    reset = 1'b0;
    stop = 1'b1; step(1); stop = 1'b0; step(3);
    start_stop(7);
    check("post_rst", int'(result), 7);

    // Random phase.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(7) == 0) start = ~start;
      if ($urandom_range(5) == 0) stop = ~stop;
      result_ready = $urandom_range(1);
      reset = ($urandom_range(499) == 0);
      step(1);
    end
    reset = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
